// File: rtl/lzc_normalizer.sv
// Two-stage leading-zero count and left-normalize; results 2 cycles after acceptance, valid/ready backpressure.
// Define LZC_NORM_EXP_EN to clamp the shift by the exponent and add E_in/E_out/UFLOW.
module lzc_normalizer #(
   parameter int WIDTH = 16,
   parameter int EXP_W = 8
) (
   input  logic                     CLK,
   input  logic                     n_RST,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         A,
`ifdef LZC_NORM_EXP_EN
   input  logic [EXP_W-1:0]         E_in,
   output logic [EXP_W-1:0]         E_out,
   output logic                     UFLOW,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         M,
   output logic [$clog2(WIDTH):0]   CNT,
   output logic                     ZERO
);
   localparam int CW = $clog2(WIDTH) + 1;

   if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || EXP_W < 1) begin : g_bad_param
      $error("lzc_normalizer: WIDTH must be a power of two >= 4 and EXP_W >= 1");
   end

   logic             s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [CW-1:0]    s1_cnt_q, s1_cnt_d;
   logic             s2_vld_q, s2_vld_d;
   logic [WIDTH-1:0] s2_m_q, s2_m_d;
   logic [CW-1:0]    s2_cnt_q, s2_cnt_d;
   logic             s2_zero_q, s2_zero_d;
   logic             s2_load, s1_adv, in_fire, s1_zero;
   logic [CW-1:0]    lzc;
   logic [WIDTH-1:0] norm_m;

   // Highest set bit wins because later iterations overwrite earlier ones.
   always_comb begin
      lzc = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (A[i]) lzc = CW'(WIDTH - 1 - i);
      end
   end

   assign s2_load  = !s2_vld_q || out_ready;
   assign s1_adv   = s1_vld_q && s2_load;
   assign in_ready = n_RST && (!s1_vld_q || s1_adv);
   assign in_fire  = in_valid && in_ready;
   assign s1_zero  = (s1_cnt_q == CW'(WIDTH));

`ifdef LZC_NORM_EXP_EN
   localparam int CMP_W = (EXP_W > CW) ? EXP_W : CW;

   logic [EXP_W-1:0] s1_e_q, s1_e_d, s2_e_q, s2_e_d;
   logic             s2_uf_q, s2_uf_d;
   logic [CMP_W-1:0] cnt_x, e_x, sh_x;

   assign cnt_x  = CMP_W'(s1_cnt_q);
   assign e_x    = CMP_W'(s1_e_q);
   // Stop shifting once the exponent would go below zero.
   assign sh_x   = (cnt_x > e_x) ? e_x : cnt_x;
   assign norm_m = s1_a_q << sh_x;
`else
   assign norm_m = s1_a_q << s1_cnt_q;
`endif

   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_a_d    = s1_a_q;
      s1_cnt_d  = s1_cnt_q;
      s2_vld_d  = s2_vld_q;
      s2_m_d    = s2_m_q;
      s2_cnt_d  = s2_cnt_q;
      s2_zero_d = s2_zero_q;
`ifdef LZC_NORM_EXP_EN
      s1_e_d    = s1_e_q;
      s2_e_d    = s2_e_q;
      s2_uf_d   = s2_uf_q;
`endif
      if (in_fire) begin
         s1_vld_d = 1'b1;
         s1_a_d   = A;
         s1_cnt_d = lzc;
`ifdef LZC_NORM_EXP_EN
         s1_e_d   = E_in;
`endif
      end else if (s1_adv) begin
         s1_vld_d = 1'b0;
      end
      if (s2_load) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_m_d    = norm_m;
            s2_cnt_d  = s1_cnt_q;
            s2_zero_d = s1_zero;
`ifdef LZC_NORM_EXP_EN
            s2_e_d    = s1_zero ? '0 : s1_e_q - EXP_W'(sh_x);
            s2_uf_d   = !s1_zero && (cnt_x > e_x);
`endif
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!n_RST) begin
         s1_vld_q  <= 1'b0;
         s1_a_q    <= '0;
         s1_cnt_q  <= '0;
         s2_vld_q  <= 1'b0;
         s2_m_q    <= '0;
         s2_cnt_q  <= '0;
         s2_zero_q <= 1'b0;
`ifdef LZC_NORM_EXP_EN
         s1_e_q    <= '0;
         s2_e_q    <= '0;
         s2_uf_q   <= 1'b0;
`endif
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_a_q    <= s1_a_d;
         s1_cnt_q  <= s1_cnt_d;
         s2_vld_q  <= s2_vld_d;
         s2_m_q    <= s2_m_d;
         s2_cnt_q  <= s2_cnt_d;
         s2_zero_q <= s2_zero_d;
`ifdef LZC_NORM_EXP_EN
         s1_e_q    <= s1_e_d;
         s2_e_q    <= s2_e_d;
         s2_uf_q   <= s2_uf_d;
`endif
      end
   end

   assign out_valid = s2_vld_q;
   assign M         = s2_m_q;
   assign CNT       = s2_cnt_q;
   assign ZERO      = s2_zero_q;
`ifdef LZC_NORM_EXP_EN
   assign E_out     = s2_e_q;
   assign UFLOW     = s2_uf_q;
`endif
endmodule
